// File: rtl/lab7_soc_sysid_pkg.sv
// Shared types and constants for the system-ID checker: FSM states, word addresses, data width.
package lab7_soc_sysid_pkg;

  localparam int SYSID_W = 32;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ID   = 3'd1,
    WAIT_ID = 3'd2,
    RD_TS   = 3'd3,
    WAIT_TS = 3'd4,
    DONE    = 3'd5
  } sysid_chk_state_t;

  function automatic logic word_match(input logic [SYSID_W-1:0] a,
                                      input logic [SYSID_W-1:0] b);
    return (a == b);
  endfunction

endpackage

// File: rtl/lab7_soc_sysid_checker_if.sv
// Avalon-MM read path between the checker (master) and the sysid control slave.
interface lab7_soc_sysid_checker_if;
  import lab7_soc_sysid_pkg::*;

  logic               sysid_address;
  logic               sysid_read;
  logic [SYSID_W-1:0] sysid_readdata;

  modport master (output sysid_address, output sysid_read, input sysid_readdata);
  modport slave  (input sysid_address, input sysid_read, output sysid_readdata);

endinterface

// File: rtl/lab7_soc_sysid_rd_wait.sv
// Slave read-latency down-counter; loaded on each strobe, shared by the ID and timestamp reads.
module lab7_soc_sysid_rd_wait (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic [1:0] load_val,
  output logic       zero
);

  logic [1:0] cnt_r;

  // load on a read strobe, otherwise count down and rest at zero
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= 2'd0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != 2'd0) begin
      cnt_r <= cnt_r - 2'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == 2'd0);

endmodule

// File: rtl/lab7_soc_sysid_checker.sv
// Reads sysid ID and timestamp words after reset or on start and flags hardware/software mismatch.
// Optional SYSID_PERIODIC_CHECK_EN: periodic recheck from DONE plus sticky mismatch_seen output.
module lab7_soc_sysid_checker
  import lab7_soc_sysid_pkg::*;
#(
  parameter logic [SYSID_W-1:0] EXPECTED_ID = 32'd0,
  parameter logic [SYSID_W-1:0] EXPECTED_TS = 32'd1488904012,
  parameter int                 RD_LAT      = 0,
  parameter int                 PERIOD      = 50_000_000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  lab7_soc_sysid_checker_if.master bus,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     id_ok,
  output logic                     ts_ok,
  output logic [SYSID_W-1:0]       id_value,
  output logic [SYSID_W-1:0]       ts_value
`ifdef SYSID_PERIODIC_CHECK_EN
  ,
  output logic                     mismatch_seen
`endif
);

  localparam logic       NO_WAIT  = (RD_LAT == 0);
  localparam logic [1:0] LOAD_VAL = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

  sysid_chk_state_t   state_r, state_nxt;
  logic               auto_r, auto_nxt;
  logic               read_r, read_nxt, addr_r, addr_nxt;
  logic               busy_nxt, done_nxt, pass_nxt, id_ok_nxt, ts_ok_nxt;
  logic [SYSID_W-1:0] id_nxt, ts_nxt;
  logic               go_s, cap_id_s, cap_ts_s, wait_load_s, wait_zero_s, period_hit_s;
  logic               fresh_id_ok_s, fresh_ts_ok_s, fresh_pass_s;

  assign bus.sysid_read    = read_r;
  assign bus.sysid_address = addr_r;

  lab7_soc_sysid_rd_wait u_rd_wait (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (wait_load_s),
    .load_val (LOAD_VAL),
    .zero     (wait_zero_s)
  );

  // next state and next output values
  always_comb begin
    state_nxt   = state_r;
    auto_nxt    = auto_r;
    read_nxt    = 1'b0;
    addr_nxt    = addr_r;
    busy_nxt    = busy;
    done_nxt    = done;
    pass_nxt    = pass;
    id_ok_nxt   = id_ok;
    ts_ok_nxt   = ts_ok;
    id_nxt      = id_value;
    ts_nxt      = ts_value;
    go_s        = 1'b0;
    cap_id_s    = 1'b0;
    cap_ts_s    = 1'b0;
    wait_load_s = 1'b0;
    // the timestamp compare uses the word being captured, not the stale register
    fresh_id_ok_s = word_match(id_value, EXPECTED_ID);
    fresh_ts_ok_s = word_match(bus.sysid_readdata, EXPECTED_TS);
    fresh_pass_s  = fresh_id_ok_s & fresh_ts_ok_s;

    case (state_r)
      IDLE:    go_s = auto_r | start;
      RD_ID: begin
        if (NO_WAIT) begin
          cap_id_s = 1'b1;
        end else begin
          wait_load_s = 1'b1;
          state_nxt   = WAIT_ID;
        end
      end
      WAIT_ID: cap_id_s = wait_zero_s;
      RD_TS: begin
        if (NO_WAIT) begin
          cap_ts_s = 1'b1;
        end else begin
          wait_load_s = 1'b1;
          state_nxt   = WAIT_TS;
        end
      end
      WAIT_TS: cap_ts_s = wait_zero_s;
      DONE:    go_s = start | period_hit_s;
      default: state_nxt = IDLE;
    endcase

    if (go_s) begin
      state_nxt = RD_ID;
      auto_nxt  = 1'b0;
      read_nxt  = 1'b1;
      addr_nxt  = ADDR_ID;
      busy_nxt  = 1'b1;
      done_nxt  = 1'b0;
      pass_nxt  = 1'b0;
      id_ok_nxt = 1'b0;
      ts_ok_nxt = 1'b0;
    end else if (cap_id_s) begin
      state_nxt = RD_TS;
      id_nxt    = bus.sysid_readdata;
      read_nxt  = 1'b1;
      addr_nxt  = ADDR_TS;
    end else if (cap_ts_s) begin
      state_nxt = DONE;
      ts_nxt    = bus.sysid_readdata;
      id_ok_nxt = fresh_id_ok_s;
      ts_ok_nxt = fresh_ts_ok_s;
      pass_nxt  = fresh_pass_s;
      done_nxt  = 1'b1;
      busy_nxt  = 1'b0;
    end else begin
      read_nxt = 1'b0;
    end
  end

  // state register and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      auto_r   <= 1'b1;
      read_r   <= 1'b0;
      addr_r   <= ADDR_ID;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      id_value <= 32'd0;
      ts_value <= 32'd0;
    end else begin
      state_r  <= state_nxt;
      auto_r   <= auto_nxt;
      read_r   <= read_nxt;
      addr_r   <= addr_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      pass     <= pass_nxt;
      id_ok    <= id_ok_nxt;
      ts_ok    <= ts_ok_nxt;
      id_value <= id_nxt;
      ts_value <= ts_nxt;
    end
  end

`ifdef SYSID_PERIODIC_CHECK_EN
  logic [31:0] period_cnt_r;

  assign period_hit_s = (state_r == DONE) && (period_cnt_r == 32'(PERIOD - 1));

  // recheck interval counter, live only while resting in DONE
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt_r <= 32'd0;
    end else if ((state_r == DONE) && !go_s) begin
      period_cnt_r <= period_cnt_r + 32'd1;
    end else begin
      period_cnt_r <= 32'd0;
    end
  end

  // sticky record of any failed check
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mismatch_seen <= 1'b0;
    end else if (cap_ts_s && !fresh_pass_s) begin
      mismatch_seen <= 1'b1;
    end else begin
      mismatch_seen <= mismatch_seen;
    end
  end
`else
  assign period_hit_s = 1'b0;
`endif

endmodule

// File: tb/tb_lab7_soc_sysid_checker.sv
// Scoreboard bench: two checker instances (RD_LAT 0 and 2) against a cycle-count reference model.
module tb_lab7_soc_sysid_checker;
  import lab7_soc_sysid_pkg::*;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1488904012;
`ifdef SYSID_PERIODIC_CHECK_EN
  localparam int PERIOD   = 10;
  localparam bit PERIODIC = 1'b1;
`else
  localparam int PERIOD   = 50_000_000;
  localparam bit PERIODIC = 1'b0;
`endif

  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    logic        id_ok;
    logic        ts_ok;
    logic        pass;
    int          done_edge;
  } exp_t;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;
  logic        start   = 1'b0;
  logic [31:0] id_word = EXP_ID;
  logic [31:0] ts_word = EXP_TS;
  int          tests   = 0;
  int          fails   = 0;
  int          cyc     = 0;

  logic [1:0]  done_w, pass_w, id_ok_w, ts_ok_w, pend_w, out_or_w;
  logic [31:0] idv_w [2];
  logic [31:0] tsv_w [2];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar ln = 0; ln < 2; ln++) begin : lane
    localparam int LAT = 2 * ln;

    lab7_soc_sysid_checker_if bus_if ();
    logic        busy, done, pass, id_ok, ts_ok, mism;
    logic [31:0] id_value, ts_value;

    lab7_soc_sysid_checker #(
      .EXPECTED_ID (EXP_ID),
      .EXPECTED_TS (EXP_TS),
      .RD_LAT      (LAT),
      .PERIOD      (PERIOD)
    ) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start),
      .bus      (bus_if),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .id_ok    (id_ok),
      .ts_ok    (ts_ok),
      .id_value (id_value),
      .ts_value (ts_value)
`ifdef SYSID_PERIODIC_CHECK_EN
      ,
      .mismatch_seen (mism)
`endif
    );
`ifndef SYSID_PERIODIC_CHECK_EN
    assign mism = 1'b0;
`endif

    assign done_w[ln]   = done;
    assign pass_w[ln]   = pass;
    assign id_ok_w[ln]  = id_ok;
    assign ts_ok_w[ln]  = ts_ok;
    assign idv_w[ln]    = id_value;
    assign tsv_w[ln]    = ts_value;
    assign out_or_w[ln] = busy | done | pass | id_ok | ts_ok | (|id_value) | (|ts_value)
                        | bus_if.sysid_read | bus_if.sysid_address | mism;

    // slave: data valid only LAT cycles after the strobe, garbage otherwise
    logic [1:0] sv_v, sv_a;
    always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        sv_v <= 2'b00;
        sv_a <= 2'b00;
      end else begin
        sv_v <= {sv_v[0], bus_if.sysid_read};
        sv_a <= {sv_a[0], bus_if.sysid_address};
      end
    end
    if (LAT == 0) begin : g_lat0
      assign bus_if.sysid_readdata = bus_if.sysid_address ? ts_word : id_word;
    end else begin : g_lat2
      assign bus_if.sysid_readdata = sv_v[1] ? (sv_a[1] ? ts_word : id_word) : 32'hBAD0_0BAD;
    end

    // reference model: a check accepted on edge E completes on edge E+2+2*LAT
    exp_t        q[$];
    logic [31:0] addr_log[$];
    logic        pend, have, auto_g, mism_m, cur_pass;
    int          done_edge, idle_cnt;
    assign pend_w[ln] = pend;

    always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        pend     <= 1'b0;
        have     <= 1'b0;
        auto_g   <= 1'b1;
        mism_m   <= 1'b0;
        idle_cnt <= 0;
        q.delete();
      end else if (pend && (cyc + 1 == done_edge)) begin
        pend     <= 1'b0;
        have     <= 1'b1;
        idle_cnt <= 0;
        mism_m   <= mism_m | !cur_pass;
      end else if (!pend && (auto_g || start || (PERIODIC && have && idle_cnt == PERIOD - 1))) begin
        pend      <= 1'b1;
        have      <= 1'b0;
        auto_g    <= 1'b0;
        done_edge <= cyc + 3 + 2 * LAT;
        cur_pass  <= (id_word == EXP_ID) && (ts_word == EXP_TS);
        q.push_back('{id_word, ts_word, id_word == EXP_ID, ts_word == EXP_TS,
                      (id_word == EXP_ID) && (ts_word == EXP_TS), cyc + 3 + 2 * LAT});
      end else if (have) begin
        idle_cnt <= idle_cnt + 1;
      end
    end

    always @(posedge clock or negedge reset_n) begin
      if (!reset_n) addr_log.delete();
      else if (bus_if.sysid_read) addr_log.push_back({31'd0, bus_if.sysid_address});
    end

    // monitor: level checks every cycle, full result check on each done rise
    logic done_prev = 1'b0;
    exp_t e;
    always @(negedge clock) begin
      chk($sformatf("lane%0d_busy", ln), {31'd0, busy}, {31'd0, pend});
      chk($sformatf("lane%0d_done", ln), {31'd0, done}, {31'd0, have});
      chk($sformatf("lane%0d_pass_level", ln), {31'd0, pass}, {31'd0, have & cur_pass});
      chk($sformatf("lane%0d_mismatch_seen", ln), {31'd0, mism}, {31'd0, PERIODIC & mism_m});
      if (done && !done_prev) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL lane%0d_unexpected_done: got done rise, required no check outstanding", ln);
        end else begin
          e = q.pop_front();
          chk($sformatf("lane%0d_latency_edge", ln), cyc, e.done_edge);
          chk($sformatf("lane%0d_id_value", ln), id_value, e.id);
          chk($sformatf("lane%0d_ts_value", ln), ts_value, e.ts);
          chk($sformatf("lane%0d_id_ok", ln), {31'd0, id_ok}, {31'd0, e.id_ok});
          chk($sformatf("lane%0d_ts_ok", ln), {31'd0, ts_ok}, {31'd0, e.ts_ok});
          chk($sformatf("lane%0d_pass", ln), {31'd0, pass}, {31'd0, e.pass});
          chk($sformatf("lane%0d_strobe_count", ln), addr_log.size(), 32'd2);
          if (addr_log.size() == 2) begin
            chk($sformatf("lane%0d_strobe0_addr", ln), addr_log[0], 32'd0);
            chk($sformatf("lane%0d_strobe1_addr", ln), addr_log[1], 32'd1);
          end
          addr_log.delete();
        end
      end
      done_prev <= done;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_w != 2'b11 && n < 80) begin
      @(negedge clock);
      n++;
    end
    tests++;
    if (done_w != 2'b11) begin
      fails++;
      $display("FAIL %s_timeout: got done=%b required 11 within 80 cycles", tag, done_w);
    end
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #1;
    chk("reset_outputs_lane0", {31'd0, out_or_w[0]}, 32'd0);
    chk("reset_outputs_lane1", {31'd0, out_or_w[1]}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // automatic check after reset: lane0 completes on the third edge
    repeat (2) @(posedge clock);
    #1 chk("lane0_done_edge2", {31'd0, done_w[0]}, 32'd0);
    @(posedge clock);
    #1 chk("lane0_done_edge3", {31'd0, done_w[0]}, 32'd1);
    chk("lane0_pass_edge3", {31'd0, pass_w[0]}, 32'd1);
    chk("lane0_id_word", idv_w[0], EXP_ID);
    chk("lane0_ts_word", tsv_w[0], EXP_TS);
    @(negedge clock);
    wait_done("auto");

    // timestamp off by one
    ts_word = EXP_TS + 32'd1;
    pulse_start();
    wait_done("ts_bad");
    chk("tsbad_pass", {30'd0, pass_w}, 32'd0);
    chk("tsbad_id_ok", {30'd0, id_ok_w}, 32'd3);
    chk("tsbad_ts_ok", {30'd0, ts_ok_w}, 32'd0);
    chk("tsbad_ts_value", tsv_w[1], EXP_TS + 32'd1);
    ts_word = EXP_TS;

    // start during lane1 WAIT_TS is ignored there; a later start restarts
    pulse_start();
    repeat (4) @(negedge clock);
    pulse_start();
    wait_done("wait_ts_start");
    repeat (3) @(negedge clock);
    pulse_start();
    chk("restart_clears_done", {30'd0, done_w}, 32'd0);
    wait_done("restart");

    // reset while lane1 is in WAIT_ID
    pulse_start();
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_lane0", {31'd0, out_or_w[0]}, 32'd0);
    chk("midreset_lane1", {31'd0, out_or_w[1]}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    wait_done("post_reset");

    // randomized starts with occasional slave word changes while both lanes are idle
    for (int i = 0; i < 800; i++) begin
      @(negedge clock);
      if (pend_w == 2'b00 && !start && ($urandom % 6 == 0)) begin
        case ($urandom % 4)
          0: begin id_word = EXP_ID;        ts_word = EXP_TS;          end
          1: begin id_word = $urandom | 1;  ts_word = EXP_TS;          end
          2: begin id_word = EXP_ID;        ts_word = EXP_TS + 32'd1;  end
          default: begin id_word = $urandom; ts_word = $urandom;       end
        endcase
      end
      start = !start && ($urandom % 5 == 0);
    end
    start = 1'b0;
    @(negedge clock);
    wait_done("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no summary, required completion before 500000");
    $fatal(1);
  end

endmodule
